// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO read-side stream controller.
package fifo_rd_pkg;

   // Word width the output buffer entry is built for.
   localparam int unsigned RD_DATA_W = 8;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } rd_state_t;

   // One buffered output word together with its end-of-packet tag.
   typedef struct packed {
      logic [RD_DATA_W-1:0] data;
      logic                 last;
   } rd_word_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Output stream bundle of the FIFO reader.
// Handshake: a word moves on a rising clk edge where m_valid && m_ready are both
// high. Once m_valid is raised it stays high, and m_data/m_last stay stable,
// until that transfer happens. m_ready may change freely and does not depend on m_valid.
interface fifo_stream_reader_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry in-order buffer of {data,last} words; entry 0 is always the head.
module skid_buf2
   import fifo_rd_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  rd_word_t push_word,
   input  logic     pop,
   output rd_word_t head,
   output logic [1:0] occ
);

   rd_word_t   mem0_q, mem0_d;
   rd_word_t   mem1_q, mem1_d;
   logic [1:0] occ_q, occ_d;
   logic       do_pop;

   // Next buffer contents: push appends behind the head, pop shifts entry 1 forward.
   always_comb begin
      mem0_d = mem0_q;
      mem1_d = mem1_q;
      occ_d  = occ_q;
      do_pop = pop && (occ_q != 2'd0);
      case ({push, do_pop})
         2'b10: begin
            if (occ_q == 2'd0) mem0_d = push_word;
            else               mem1_d = push_word;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            mem0_d = mem1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            // Occupancy is unchanged; the new word lands behind whatever remains.
            if (occ_q == 2'd1) begin
               mem0_d = push_word;
            end else begin
               mem0_d = mem1_q;
               mem1_d = push_word;
            end
         end
         default: ;
      endcase
   end

   // Buffer registers; reset empties the buffer and zeroes the head word.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem0_q <= '0;
         mem1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         mem0_q <= mem0_d;
         mem1_q <= mem1_d;
         occ_q  <= occ_d;
      end
   end

   assign head = mem0_q;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for sync_fifo: pops words and re-emits them as fixed-length
// packets on a valid/ready stream. Packets start only when the FIFO is above its
// almost-empty threshold, or while a flush is pending.
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RD_DATA_W,
   parameter int unsigned PKT_LEN    = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic                  fifo_almost_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   fifo_stream_reader_if.master  m_if,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output rd_state_t             dbg_state,
   output logic                  dbg_flush_pending
);

   localparam int unsigned      BEAT_W    = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

   rd_state_t            state_q, state_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;
   logic                 in_flight_q, in_flight_d;
   logic                 tag_q, tag_d;
   logic                 flush_pending_q, flush_pending_d;
   logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

   rd_word_t   head;
   rd_word_t   push_word;
   logic [1:0] occ;
   logic       out_valid;
   logic       pop;
   logic [2:0] slots;
   logic       room;
   logic       hold_boundary;
   logic       rd_en;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && m_if.m_ready;

   // Issue decision: only read when the word already requested plus what sits in the
   // buffer still leaves a free slot after this cycle's pop. A STREAM packet never
   // starts while the FIFO is at its almost-empty threshold.
   always_comb begin
      slots         = {1'b0, occ} + {2'b00, in_flight_q};
      room          = slots < (3'd2 + {2'b00, pop});
      hold_boundary = (state_q == STREAM) && (beat_q == '0) && fifo_almost_empty;
      rd_en         = (state_q != IDLE) && !fifo_empty && room && !hold_boundary;
   end

   // Next-state logic for the FSM, beat counter, flush request and packet count.
   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      in_flight_d     = rd_en;
      tag_d           = rd_en && (beat_q == BEAT_LAST);
      flush_pending_d = flush_pending_q || flush;
      pkt_count_d     = pkt_count_q + CNT_WIDTH'(pop && head.last);

      if (rd_en) begin
         beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (flush_pending_q && !fifo_empty) state_d = FLUSH;
            else if (!fifo_almost_empty)        state_d = STREAM;
         end
         STREAM: begin
            // A partial packet keeps reading; only a packet boundary may stop.
            if (hold_boundary) state_d = IDLE;
         end
         FLUSH: begin
            // Leave only at a packet boundary with nothing left; a trailing partial
            // packet holds here until the rest of it arrives.
            if ((beat_q == '0) && fifo_empty) begin
               state_d         = IDLE;
               flush_pending_d = flush;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All controller registers; reset abandons any packet in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         beat_q          <= '0;
         in_flight_q     <= 1'b0;
         tag_q           <= 1'b0;
         flush_pending_q <= 1'b0;
         pkt_count_q     <= '0;
      end else begin
         state_q         <= state_d;
         beat_q          <= beat_d;
         in_flight_q     <= in_flight_d;
         tag_q           <= tag_d;
         flush_pending_q <= flush_pending_d;
         pkt_count_q     <= pkt_count_d;
      end
   end

   // FIFO read data arrives one cycle after the pop and carries the tag captured at issue.
   always_comb begin
      push_word.data = fifo_data;
      push_word.last = tag_q;
   end

   skid_buf2 u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (in_flight_q),
      .push_word (push_word),
      .pop       (pop),
      .head      (head),
      .occ       (occ)
   );

   assign fifo_rd_en        = rd_en;
   assign m_if.m_valid      = out_valid;
   assign m_if.m_data       = head.data;
   assign m_if.m_last       = head.last;
   assign pkt_count         = pkt_count_q;
   assign dbg_state         = state_q;
   assign dbg_flush_pending = flush_pending_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a queue-based FIFO model and a
// packet-level output model.
module tb_fifo_stream_reader;
   import fifo_rd_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        fifo_empty, fifo_almost_empty, fifo_rd_en;
   logic        flush = 1'b0;
   logic [7:0]  fifo_data = 8'h00;
   logic [15:0] pkt_count;
   rd_state_t   dbg_state;
   logic        dbg_flush_pending;

   fifo_stream_reader_if #(.DATA_WIDTH(8)) m_if ();

   fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .fifo_empty        (fifo_empty),
      .fifo_almost_empty (fifo_almost_empty),
      .fifo_data         (fifo_data),
      .fifo_rd_en        (fifo_rd_en),
      .flush             (flush),
      .m_if              (m_if),
      .pkt_count         (pkt_count),
      .dbg_state         (dbg_state),
      .dbg_flush_pending (dbg_flush_pending)
   );

   // ---------------- FIFO model: depth 16, 1-cycle read latency ----------------
   logic [7:0] fq[$];
   int wr_total = 0;
   int rd_total = 0;
   int fcnt;
   assign fcnt              = wr_total - rd_total;
   assign fifo_empty        = (fcnt == 0);
   assign fifo_almost_empty = (fcnt <= 4);

   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
         rd_total <= wr_total;
      end else if (fifo_rd_en && fq.size() > 0) begin
         fifo_data <= fq.pop_front();
         rd_total  <= rd_total + 1;
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];       // {data,last} in emission order
   int         widx = 0;       // word index since reset: every 4th closes a packet
   logic [15:0] exp_pkt = 16'h0;
   int         acc_cnt = 0;
   logic [8:0] last_word = 9'h0;
   int         cyc_n = 0;
   int         acc_cyc[$];
   logic       stall_prev = 1'b0;
   logic [8:0] prev_word = 9'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_words(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] d;
         d = base + 8'(i);
         fq.push_back(d);
         wr_total++;
         exp_q.push_back({d, (widx % 4) == 3});
         widx++;
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Run until n words have been accepted in total; pattern=1 uses ready 1,0,0,1.
   task automatic run_until(input string name, input int n, input bit pattern);
      int cyc;
      cyc = 0;
      while (acc_cnt < n && cyc < 300) begin
         if (pattern) m_if.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         else         m_if.m_ready = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      m_if.m_ready = 1'b1;
      chk(name, 32'(acc_cnt), 32'(n));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_m_valid"}, 32'(m_if.m_valid), 32'd0);
      chk({tag, "_m_data"},  32'(m_if.m_data),  32'd0);
      chk({tag, "_m_last"},  32'(m_if.m_last),  32'd0);
      chk({tag, "_rd_en"},   32'(fifo_rd_en),   32'd0);
      chk({tag, "_pkt"},     32'(pkt_count),    32'd0);
      chk({tag, "_state"},   32'(dbg_state),    32'(IDLE));
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      cyc_n++;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         chk("pkt_count", 32'(pkt_count), 32'(exp_pkt));
         chk("occ_bound", 32'(dut.occ <= 2'd2), 32'd1);
         if (fifo_rd_en) chk("rd_on_empty", 32'(fcnt != 0), 32'd1);
         if (stall_prev) begin
            chk("stall_valid", 32'(m_if.m_valid), 32'd1);
            chk("stall_word",  32'({m_if.m_data, m_if.m_last}), 32'(prev_word));
         end
         if (m_if.m_valid && m_if.m_ready) begin
            logic [8:0] w;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_word actual=0x%0h required=none t=%0t",
                        {m_if.m_data, m_if.m_last}, $time);
            end else begin
               w = exp_q.pop_front();
               if ({m_if.m_data, m_if.m_last} !== w) begin
                  errors++;
                  $display("FAIL out_word actual=0x%0h required=0x%0h t=%0t",
                           {m_if.m_data, m_if.m_last}, w, $time);
               end
               if (w[0]) exp_pkt = exp_pkt + 16'd1;
            end
            acc_cnt++;
            acc_cyc.push_back(cyc_n);
            last_word = {m_if.m_data, m_if.m_last};
         end
         stall_prev = m_if.m_valid && !m_if.m_ready;
         prev_word  = {m_if.m_data, m_if.m_last};
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      m_if.m_ready = 1'b0;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      chk_reset_outputs("reset");

      // 1: twelve words, always ready -> two packets, four words left behind
      m_if.m_ready = 1'b1;
      acc_cyc.delete();
      push_words(8'h00, 12);
      run_until("t1_accepts", 8, 1'b0);
      chk("t1_back_to_back", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
      idle(2);
      for (int i = 0; i < 8; i++) begin
         chk("t1_rd_idle", 32'(fifo_rd_en), 32'd0);
         idle(1);
      end
      chk("t1_last_word", 32'(last_word), 32'h00F);   // 0x07 with last
      chk("t1_pkt", 32'(pkt_count), 32'd2);
      chk("t1_fifo_left", 32'(fcnt), 32'd4);
      chk("t1_state", 32'(dbg_state), 32'(IDLE));

      // 2: flush drains the remaining complete packet
      pulse_flush();
      run_until("t2_accepts", 12, 1'b0);
      idle(3);
      chk("t2_last_word", 32'(last_word), 32'h017);   // 0x0B with last
      chk("t2_pkt", 32'(pkt_count), 32'd3);
      chk("t2_state", 32'(dbg_state), 32'(IDLE));
      chk("t2_pending", 32'(dbg_flush_pending), 32'd0);

      // 3: eight words under 1,0,0,1 backpressure
      push_words(8'h20, 8);
      pulse_flush();
      run_until("t3_accepts", 20, 1'b1);
      idle(3);
      chk("t3_last_word", 32'(last_word), 32'h04F);   // 0x27 with last
      chk("t3_pkt", 32'(pkt_count), 32'd5);
      chk("t3_model_empty", 32'(exp_q.size()), 32'd0);

      // 4: partial packet under flush holds until the fourth word arrives
      push_words(8'h40, 3);
      pulse_flush();
      run_until("t4a_accepts", 23, 1'b0);
      idle(4);
      chk("t4_partial_word", 32'(last_word), 32'h084); // 0x42 without last
      chk("t4_hold_state", 32'(dbg_state), 32'(FLUSH));
      chk("t4_hold_pkt", 32'(pkt_count), 32'd5);
      push_words(8'h43, 1);
      run_until("t4b_accepts", 24, 1'b0);
      idle(3);
      chk("t4_last_word", 32'(last_word), 32'h087);   // 0x43 with last
      chk("t4_state", 32'(dbg_state), 32'(IDLE));
      chk("t4_pending", 32'(dbg_flush_pending), 32'd0);
      chk("t4_pkt", 32'(pkt_count), 32'd6);

      // 5: reset mid-packet with a word buffered
      m_if.m_ready = 1'b0;
      push_words(8'h60, 8);
      begin
         int t;
         t = 0;
         while (!m_if.m_valid && t < 20) begin idle(1); t++; end
         chk("t5_buffered", 32'(m_if.m_valid), 32'd1);
      end
      rst = 1'b1;
      exp_q.delete();
      widx = 0;
      exp_pkt = 16'h0;
      idle(1);
      rst = 1'b0;
      chk_reset_outputs("t5_reset");
      m_if.m_ready = 1'b1;
      begin
         int base;
         base = acc_cnt;
         push_words(8'h70, 4);
         pulse_flush();
         run_until("t5_accepts", base + 4, 1'b0);
      end
      idle(3);
      chk("t5_last_word", 32'(last_word), 32'h0E7);   // 0x73 with last
      chk("t5_pkt", 32'(pkt_count), 32'd1);

      // 6: pkt_count wraps from 0xFFFF to 0
      force dut.pkt_count_q = 16'hFFFF;
      #1;
      release dut.pkt_count_q;
      exp_pkt = 16'hFFFF;
      chk("t6_preload", 32'(pkt_count), 32'h0000FFFF);
      begin
         int base;
         base = acc_cnt;
         push_words(8'h80, 4);
         pulse_flush();
         run_until("t6_accepts", base + 4, 1'b0);
      end
      idle(3);
      chk("t6_last_word", 32'(last_word), 32'h107);   // 0x83 with last
      chk("t6_wrap", 32'(pkt_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
